// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared types and constants for the arithmetic datapath
package arith_pkg;

    localparam int ARITH_W = 8;
    localparam logic [2:0] ITER_LAST = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add_8bit.sv
// rtl/add_8bit.sv - 8-bit ripple-carry adder exposing every stage carry
module add_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] s,
    output logic [7:0] c1
);

    always_comb begin
        logic c;
        s  = '0;
        c1 = '0;
        c  = ci;
        for (int i = 0; i < 8; i++) begin
            s[i]  = a[i] ^ b[i] ^ c;
            c1[i] = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
            c     = c1[i];
        end
    end

endmodule

// File: rtl/mul_8bit_seq.sv
// rtl/mul_8bit_seq.sv - sequential 8x8 unsigned shift-and-add multiplier
module mul_8bit_seq
    import arith_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ARITH_W-1:0]     a,
    input  logic [ARITH_W-1:0]     b,
    output logic                   busy,
    output logic                   done,
    output logic [2*ARITH_W-1:0]   p
);

    state_t state, state_nxt;

    logic [ARITH_W-1:0]   m;
    logic [ARITH_W-1:0]   acc;
    logic [ARITH_W-1:0]   q;
    logic [2:0]           cnt;
    logic [ARITH_W-1:0]   s;
    logic [ARITH_W-1:0]   c1;
    logic                 co;
    logic                 unused_carries;
    logic [2*ARITH_W-1:0] shift_nxt;

    add_8bit u_add (
        .a  (acc),
        .b  (m),
        .ci (1'b0),
        .s  (s),
        .c1 (c1)
    );

    assign co             = c1[ARITH_W-1];
    assign unused_carries = ^c1[ARITH_W-2:0];

    // Post-shift {acc,q}; the carry-out becomes the new acc MSB so 0xFF*0xFF survives.
    assign shift_nxt = q[0] ? {co, s, q[ARITH_W-1:1]} : {1'b0, acc, q[ARITH_W-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == ITER_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m   <= '0;
            acc <= '0;
            q   <= '0;
            cnt <= '0;
            p   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m   <= a;
                        q   <= b;
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                CALC: begin
                    {acc, q} <= shift_nxt;
                    cnt      <= cnt + 3'd1;
                    if (cnt == ITER_LAST) p <= shift_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_8bit_seq.sv
// tb/tb_mul_8bit_seq.sv - self-checking bench for mul_8bit_seq
module tb_mul_8bit_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  a = 8'h00;
    logic [7:0]  b = 8'h00;
    logic        busy;
    logic        done;
    logic [15:0] p;

    int checks = 0;
    int failures = 0;

    mul_8bit_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted request finishes 9 edges later; the product is a*b.
    int          phase = 0;
    logic [15:0] pend_prod = '0;
    logic [15:0] exp_p = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            phase = 0;
            exp_p = '0;
        end else if (phase == 0) begin
            if (start) begin
                pend_prod = 16'(a) * 16'(b);
                phase = 1;
            end
        end else if (phase == 9) begin
            phase = 0;
        end else begin
            phase = phase + 1;
            if (phase == 9) exp_p = pend_prod;
        end
    end

    always @(negedge clk) begin
        check("model_busy", {31'b0, busy}, {31'b0, phase != 0});
        check("model_done", {31'b0, done}, {31'b0, phase == 9});
        check("model_p", {16'b0, p}, {16'b0, exp_p});
    end

    task automatic accept(input logic [7:0] av, input logic [7:0] bv);
        @(posedge clk);
        #2;
        start = 1'b1;
        a = av;
        b = bv;
        @(posedge clk);
        #2;
        start = 1'b0;
        a = ~av;
        b = ~bv;
    endtask

    // Observes from the negedge after the accepting edge (index 0) until busy drops.
    task automatic observe(output int done_idx, output int done_cnt, output int busy_cnt,
                           output logic [15:0] p_done);
        done_idx = -1;
        done_cnt = 0;
        busy_cnt = 0;
        p_done   = 16'hxxxx;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_idx < 0) begin
                    done_idx = i;
                    p_done = p;
                end
            end
            if (!busy && i > 0) break;
        end
    endtask

    typedef struct {
        logic [7:0]  av;
        logic [7:0]  bv;
        logic [15:0] prod;
    } vec_t;

    vec_t vecs[5] = '{
        '{8'h0D, 8'h0B, 16'h008F},
        '{8'hFF, 8'hFF, 16'hFE01},
        '{8'h80, 8'h02, 16'h0100},
        '{8'h00, 8'hFF, 16'h0000},
        '{8'hFF, 8'h00, 16'h0000}
    };

    initial begin
        int          di, dc, bc, idx0, idx1, ndone;
        logic [15:0] pd;

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_p", {16'b0, p}, 32'd0);
        #1 rst = 1'b0;

        foreach (vecs[k]) begin
            accept(vecs[k].av, vecs[k].bv);
            observe(di, dc, bc, pd);
            check($sformatf("vec%0d_p", k), {16'b0, pd}, {16'b0, vecs[k].prod});
            check($sformatf("vec%0d_done_idx", k), di, 32'd8);
            check($sformatf("vec%0d_done_cnt", k), dc, 32'd1);
            check($sformatf("vec%0d_busy_cycles", k), bc, 32'd9);
            @(negedge clk);
            check($sformatf("vec%0d_p_hold", k), {16'b0, p}, {16'b0, vecs[k].prod});
        end

        // Re-pulse start mid-operation: must be ignored.
        accept(8'h03, 8'h05);
        repeat (2) @(posedge clk);
        #2;
        start = 1'b1;
        a = 8'h10;
        b = 8'h10;
        @(posedge clk);
        #2;
        start = 1'b0;
        observe(di, dc, bc, pd);
        check("repulse_p", {16'b0, pd}, 32'h000F);
        check("repulse_done_cnt", dc, 32'd1);
        repeat (12) begin
            @(negedge clk);
            check("repulse_no_second", {31'b0, busy}, 32'd0);
        end

        // Reset mid-operation discards the product.
        accept(8'h12, 8'h34);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_p", {16'b0, p}, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midrst_no_done", ndone, 32'd0);
        accept(8'h12, 8'h34);
        observe(di, dc, bc, pd);
        check("after_rst_p", {16'b0, pd}, 32'h03A8);

        // Back-to-back with start held high.
        @(posedge clk);
        #2;
        start = 1'b1;
        a = 8'h07;
        b = 8'h09;
        @(posedge clk);
        idx0 = -1;
        idx1 = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                check("b2b_p", {16'b0, p}, 32'h003F);
                if (idx0 < 0) idx0 = i;
                else if (idx1 < 0) idx1 = i;
            end
        end
        start = 1'b0;
        check("b2b_first_done", idx0, 32'd8);
        check("b2b_second_done", idx1, 32'd18);
        repeat (3) @(negedge clk);
        check("final_idle", {31'b0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
